// File: rtl/matrix_result_drain_pkg.sv
// Shared types and sizing for the output-BRAM drain path.
// Contents: result-lane geometry, BRAM address width, read latency,
// derived holding-FIFO depth, drain FSM state encoding and the ReLU helper.
package matrix_result_drain_pkg;

    localparam int OUTPUT_WIDTH      = 32;
    localparam int LANES             = 4;
    localparam int ADDR_WIDTH        = 12;
    localparam int BRAM_READ_LATENCY = 3;
    localparam int FIFO_DEPTH        = BRAM_READ_LATENCY + 2;
    localparam int CNT_WIDTH         = ADDR_WIDTH + 1;
    localparam int CREDIT_WIDTH      = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_WIDTH        = LANES * OUTPUT_WIDTH;

    typedef logic [ADDR_WIDTH-1:0]                output_bram_addr_t;
    typedef logic [CNT_WIDTH-1:0]                 drain_count_t;
    typedef logic [LANES-1:0][OUTPUT_WIDTH-1:0]   result_word_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } drain_state_e;

    // Clamp every signed lane that is negative to zero.
    function automatic result_word_t relu_word(input result_word_t w);
        result_word_t r;
        r = w;
        for (int i = 0; i < LANES; i++) begin
            if (w[i][OUTPUT_WIDTH-1]) begin
                r[i] = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_result_drain_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever !empty.
// Ports: clk, rst_n (async active-low), push/push_data, pop, head,
//        count (occupancy), full, empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module matrix_result_drain_fifo #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/matrix_result_drain.sv
// Drains the result matrix from output BRAM and streams it on valid/ready.
// Ports: clk, rst_n (async active-low), start, base_addr, word_count,
//        busy, done, rd_en, rd_addr, rd_data, m_valid, m_ready, m_data, m_last.
// Build option: MATRIX_DRAIN_RELU_EN clamps negative signed lanes to zero
// as data enters the holding FIFO; without it lanes pass through bit-exact.
//
// state | meaning
// IDLE  | waiting for start; busy only during the accepting cycle
// RUN   | issuing reads, limited by outstanding credit
// FLUSH | all reads issued; waiting for returns and the last handshake
// DONE  | one-cycle done pulse
module matrix_result_drain
    import matrix_result_drain_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [ADDR_WIDTH:0]       word_count,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     rd_addr,
    input  logic [WORD_WIDTH-1:0]     rd_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [WORD_WIDTH-1:0]     m_data,
    output logic                      m_last
);

    drain_state_e                  state;
    drain_state_e                  state_next;
    drain_count_t                  count_q;
    drain_count_t                  issued;
    drain_count_t                  beats_out;
    logic [CREDIT_WIDTH-1:0]       in_flight;
    logic [CREDIT_WIDTH-1:0]       fifo_count;
    logic [CREDIT_WIDTH:0]         credit_used;
    logic [BRAM_READ_LATENCY-1:0]  rd_pipe;
    logic                          pipe_out;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          issue_ok;
    logic                          start_accept;
    logic                          beat;
    result_word_t                  push_word;
    result_word_t                  fifo_head;

    assign start_accept = (state == S_IDLE) && start;
    assign pipe_out     = rd_pipe[BRAM_READ_LATENCY-1];
    assign credit_used  = {1'b0, in_flight} + {1'b0, fifo_count};
    // Reads in flight plus queued words never exceed the FIFO depth, so
    // every returning word has a guaranteed slot regardless of m_ready.
    assign issue_ok     = (issued != count_q) && !fifo_full &&
                          (credit_used < (CREDIT_WIDTH+1)'(FIFO_DEPTH));

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : fifo_head;
    assign beat    = m_valid && m_ready;
    assign m_last  = m_valid && (beats_out == count_q - CNT_WIDTH'(1));

`ifdef MATRIX_DRAIN_RELU_EN
    assign push_word = relu_word(result_word_t'(rd_data));
`else
    assign push_word = result_word_t'(rd_data);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = (word_count == '0) ? S_DONE : S_RUN;
            S_RUN:   if (rd_en && (issued == count_q - CNT_WIDTH'(1))) state_next = S_FLUSH;
            S_FLUSH: if ((in_flight == '0) && fifo_empty && (beats_out == count_q))
                         state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // busy covers the accepting cycle itself, so it is high from the start
    // pulse through the done pulse.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        rd_en = 1'b0;
        case (state)
            S_IDLE:  busy = start;
            S_RUN:   begin busy = 1'b1; rd_en = issue_ok; end
            S_FLUSH: busy = 1'b1;
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            count_q   <= '0;
            issued    <= '0;
            beats_out <= '0;
            in_flight <= '0;
            rd_pipe   <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | BRAM_READ_LATENCY'(rd_en);
            if (start_accept) begin
                rd_addr   <= base_addr;
                count_q   <= word_count;
                issued    <= '0;
                beats_out <= '0;
            end else begin
                if (rd_en) begin
                    rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    issued  <= issued + CNT_WIDTH'(1);
                end
                if (beat) begin
                    beats_out <= beats_out + CNT_WIDTH'(1);
                end
            end
            case ({rd_en, pipe_out})
                2'b10:   in_flight <= in_flight + CREDIT_WIDTH'(1);
                2'b01:   in_flight <= in_flight - CREDIT_WIDTH'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    matrix_result_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_out),
        .push_data (push_word),
        .pop       (beat),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_matrix_result_drain.sv
module tb_matrix_result_drain;

    localparam int LAT   = 3;
    localparam int DEPTH = 5;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [11:0]  base_addr = '0;
    logic [12:0]  word_count = '0;
    logic         busy, done, rd_en, m_valid, m_last;
    logic [11:0]  rd_addr;
    logic [127:0] rd_data, m_data;
    logic         m_ready = 1'b1;
    logic         toggle_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_addr [$];
    beat_t       exp_beats [$];

    int cyc = 0;
    int test_no = 0;
    int seen_test = 0;
    int start_cyc = 0;
    int rd_cnt, valid_cnt, done_cnt, busy_cnt;
    int first_rd, first_valid, last_cyc, done_cyc;
    int n_rd = 0;
    int n_beats = 0;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic         prev_last = 1'b0;

    logic [127:0] bram_pipe [LAT] = '{default: '0};

    matrix_result_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (toggle_ready) m_ready = ~m_ready;
        else              m_ready = 1'b1;
    end

    // BRAM contents: lane i of word a = a*4+i, word 100 lane 0 is negative.
    function automatic logic [127:0] word_of(input logic [11:0] a);
        logic [127:0] w;
        for (int i = 0; i < 4; i++) w[i*32 +: 32] = 32'(a) * 32'd4 + 32'(i);
        if (a == 12'd100) w[31:0] = 32'hFFFF_FFFB;
        return w;
    endfunction

    function automatic logic [127:0] exp_word(input logic [11:0] a);
        logic [127:0] w;
        w = word_of(a);
`ifdef MATRIX_DRAIN_RELU_EN
        for (int i = 0; i < 4; i++) if (w[i*32+31]) w[i*32 +: 32] = '0;
`endif
        return w;
    endfunction

    always @(posedge clk) begin
        bram_pipe[0] <= rd_en ? word_of(rd_addr) : '0;
        for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign rd_data = bram_pipe[LAT-1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: address and beat scoreboards, hold-while-stalled, credit bound.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_addr.delete();
            exp_beats.delete();
            prev_stall = 1'b0;
            n_rd = 0;
            n_beats = 0;
        end else begin
            if (test_no != seen_test) begin
                seen_test = test_no;
                rd_cnt = 0; valid_cnt = 0; done_cnt = 0; busy_cnt = 0;
                first_rd = -1; first_valid = -1; last_cyc = -1; done_cyc = -1;
            end
            if (rd_en) begin
                rd_cnt++;
                n_rd++;
                if (first_rd < 0) first_rd = cyc;
                if (exp_addr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected: actual rd_en at addr %0d required no read", rd_addr);
                end else begin
                    check("rd_addr", 128'(rd_addr), 128'(exp_addr.pop_front()));
                end
            end
            check("credit_bound", 128'((n_rd - n_beats) <= DEPTH), 128'(1));
            if (prev_stall) begin
                check("hold_valid", 128'(m_valid), 128'(1));
                check("hold_data", m_data, prev_data);
                check("hold_last", 128'(m_last), 128'(prev_last));
            end
            if (m_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (m_valid && m_ready) begin
                n_beats++;
                if (exp_beats.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL beat_unexpected: actual beat %0h required none", m_data);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat_data", m_data, b.data);
                    check("beat_last", 128'(m_last), 128'(b.last));
                end
                if (m_last) last_cyc = cyc;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy) busy_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic start_drain(input int t, input int b, input int n);
        @(posedge clk); #1;
        test_no    = t;
        base_addr  = 12'(b);
        word_count = 13'(n);
        start      = 1'b1;
        start_cyc  = cyc;
        for (int k = 0; k < n; k++) begin
            logic [11:0] a;
            a = 12'(b + k);
            exp_addr.push_back(a);
            exp_beats.push_back('{data: exp_word(a), last: (k == n - 1)});
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(name, 128'(seen), 128'(1));
        repeat (3) @(posedge clk);
    endtask

    task automatic check_drained(input string name, input int n);
        check({name, "_rd_cnt"}, 128'(rd_cnt), 128'(n));
        check({name, "_done_cnt"}, 128'(done_cnt), 128'(1));
        check({name, "_addr_left"}, 128'(exp_addr.size()), 128'(0));
        check({name, "_beats_left"}, 128'(exp_beats.size()), 128'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctrl"}, 128'({busy, done, rd_en, m_valid, m_last}), 128'(0));
        check({name, "_rd_addr"}, 128'(rd_addr), 128'(0));
        check({name, "_m_data"}, m_data, 128'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic drain
        start_drain(1, 0, 4);
        wait_done("basic_done", 100);
        check_drained("basic", 4);
        check("basic_first_rd", 128'(first_rd - start_cyc), 128'(1));
        check("basic_first_valid", 128'(first_valid - first_rd), 128'(LAT + 1));
        check("basic_valid_cnt", 128'(valid_cnt), 128'(4));
        check("basic_done_after_last", 128'(done_cyc - last_cyc), 128'(2));

        // Backpressure plus an ignored start while running
        toggle_ready = 1'b1;
        start_drain(2, 0, 16);
        @(posedge clk); #1;
        base_addr  = 12'd200;
        word_count = 13'd3;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("bp_done", 300);
        check_drained("bp", 16);
        toggle_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Zero-length drain
        start_drain(3, 5, 0);
        wait_done("zero_done", 20);
        check("zero_busy_cycles", 128'(busy_cnt), 128'(2));
        check("zero_rd_cnt", 128'(rd_cnt), 128'(0));
        check("zero_valid_cnt", 128'(valid_cnt), 128'(0));
        check("zero_done_cnt", 128'(done_cnt), 128'(1));

        // Address wrap
        start_drain(4, 4094, 4);
        wait_done("wrap_done", 100);
        check_drained("wrap", 4);

        // Negative lane
        start_drain(5, 100, 2);
        wait_done("relu_done", 100);
        check_drained("relu", 2);

        // Reset mid-drain
        start_drain(6, 40, 8);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        check("abort_no_done", 128'(done_cnt), 128'(0));
        check("abort_idle", 128'({busy, rd_en, m_valid}), 128'(0));

        start_drain(7, 8, 4);
        wait_done("post_reset_done", 100);
        check_drained("post_reset", 4);

        // Whole BRAM
        start_drain(8, 0, 4096);
        wait_done("full_done", 6000);
        check_drained("full", 4096);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
